muxn_stream: RTL and testbench

//   Parametrised N-input, W-bit streaming multiplexer. It succeeds the 2:1 mux

---
 rtl/muxn_stream_if.sv | 32 +++
 rtl/muxn_stream.sv | 115 +++++++++++
 tb/tb_muxn_stream.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/muxn_stream_if.sv
`default_nettype none
// ============================================================================
// Module  : muxn_stream_if
// Brief   : Bundle of N producer streams, channel select and one consumer stream
// Revision: 1.0  initial release
// ============================================================================
interface muxn_stream_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_ch;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
endinterface
`default_nettype wire

// File: rtl/muxn_stream.sv
`default_nettype none
// ============================================================================
// Module  : muxn_stream
// Brief   : N:1 streaming mux, registered output, select or round-robin grant
// Revision: 1.0  initial release
// ============================================================================
module muxn_stream #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    muxn_stream_if.slave bus
);
    localparam int SW = $clog2(N);

    logic          load_en;
    logic          grant_vld;
    logic [SW-1:0] grant;
    logic          xfer;
    logic [W-1:0]  grant_data;
    logic [W-1:0]  data_reg;
    logic [SW-1:0] ch_reg;
    logic          valid_reg;

    // A single output register still sustains one beat per clock.
    assign load_en = ~valid_reg | bus.out_ready;
    assign xfer    = load_en & grant_vld;

    generate
        if (MODE == 0) begin : g_sel
            // Out-of-range select values match no channel and give no grant.
            always_comb begin
                grant_vld = 1'b0;
                grant     = '0;
                for (int i = 0; i < N; i++) begin
                    if (bus.sel == SW'(i) && bus.in_valid[i]) begin
                        grant_vld = 1'b1;
                        grant     = SW'(i);
                    end
                end
            end
        end else begin : g_rr
            logic [SW-1:0] rr_ptr;
            logic          unused_sel;

            assign unused_sel = ^bus.sel;

            // Descending scan so the last hit is the first channel from rr_ptr.
            always_comb begin
                int idx;
                grant_vld = 1'b0;
                grant     = '0;
                idx       = 0;
                for (int k = N - 1; k >= 0; k--) begin
                    idx = int'(rr_ptr) + k;
                    if (idx >= N) begin
                        idx = idx - N;
                    end
                    if (bus.in_valid[SW'(idx)]) begin
                        grant_vld = 1'b1;
                        grant     = SW'(idx);
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rr_ptr <= '0;
                end else if (xfer) begin
                    rr_ptr <= (grant == SW'(N - 1)) ? '0 : grant + 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SW'(i)) begin
                grant_data = bus.in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (!rst && xfer && grant == SW'(i)) begin
                bus.in_ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg  <= '0;
            ch_reg    <= '0;
            valid_reg <= 1'b0;
        end else if (load_en) begin
            valid_reg <= grant_vld;
            if (grant_vld) begin
                data_reg <= grant_data;
                ch_reg   <= grant;
            end
        end
    end

    assign bus.out_data  = data_reg;
    assign bus.out_ch    = ch_reg;
    assign bus.out_valid = valid_reg;

endmodule
`default_nettype wire

// File: tb/tb_muxn_stream.sv
`default_nettype none
// ============================================================================
// Module  : tb_muxn_stream
// Brief   : Directed and scoreboarded checks of muxn_stream in several configurations
// Revision: 1.0  initial release
// ============================================================================
module tb_muxn_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    muxn_stream_if #(.N(4), .W(8))  b0 ();
    muxn_stream_if #(.N(4), .W(8))  b1 ();
    muxn_stream_if #(.N(2), .W(1))  b2 ();
    muxn_stream_if #(.N(5), .W(32)) b3 ();

    muxn_stream #(.N(4), .W(8),  .MODE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    muxn_stream #(.N(4), .W(8),  .MODE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    muxn_stream #(.N(2), .W(1),  .MODE(1)) u2 (.clk(clk), .rst(rst), .bus(b2));
    muxn_stream #(.N(5), .W(32), .MODE(0)) u3 (.clk(clk), .rst(rst), .bus(b3));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out0(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
        check({tag, "_valid"}, 64'(b0.out_valid), 64'(v));
        check({tag, "_data"},  64'(b0.out_data),  64'(d));
        check({tag, "_ch"},    64'(b0.out_ch),    64'(c));
    endtask

    initial begin
        logic [39:0] q2[$];
        logic [39:0] q3[$];
        logic [39:0] item;
        logic [63:0] expv;
        logic        le;
        int          g;
        int          ptr2;

        b0.in_valid = '0; b0.in_data = '0; b0.sel = '0; b0.out_ready = 1'b0;
        b1.in_valid = '0; b1.in_data = '0; b1.sel = '0; b1.out_ready = 1'b0;
        b2.in_valid = '0; b2.in_data = '0; b2.sel = '0; b2.out_ready = 1'b0;
        b3.in_valid = '0; b3.in_data = '0; b3.sel = '0; b3.out_ready = 1'b0;

        // Reset state with a would-be grant present
        b0.in_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
        b0.in_valid  = 4'b1111;
        b0.sel       = 2'd2;
        b0.out_ready = 1'b1;
        tick();
        check("rst_in_ready", 64'(b0.in_ready), 64'(4'b0000));
        check_out0("rst", 1'b0, 8'h00, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // Select mode
        #1;
        check("sel2_in_ready", 64'(b0.in_ready), 64'(4'b0100));
        tick();
        check_out0("sel2", 1'b1, 8'hA5, 2'd2);
        b0.sel      = 2'd3;
        b0.in_valid = 4'b0111;
        #1;
        check("sel3_in_ready", 64'(b0.in_ready), 64'(4'b0000));
        tick();
        check_out0("sel3_nogrant", 1'b0, 8'hA5, 2'd2);

        // Backpressure
        b0.sel      = 2'd1;
        b0.in_valid = 4'b1111;
        tick();
        check_out0("bp_load", 1'b1, 8'h22, 2'd1);
        b0.out_ready = 1'b0;
        b0.sel       = 2'd0;
        #1;
        check("bp_in_ready0", 64'(b0.in_ready), 64'(4'b0000));
        for (int k = 0; k < 5; k++) begin
            tick();
            b0.in_valid = (k[0]) ? 4'b1111 : 4'b0001;
            b0.sel      = 2'(k);
            #1;
            check("bp_stall_ready", 64'(b0.in_ready), 64'(4'b0000));
            check_out0("bp_stall", 1'b1, 8'h22, 2'd1);
        end
        b0.sel       = 2'd0;
        b0.in_valid  = 4'b0001;
        b0.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(b0.in_ready), 64'(4'b0001));
        tick();
        check_out0("bp_release", 1'b1, 8'h11, 2'd0);

        // Asynchronous reset mid-stream
        #2;
        rst = 1'b1;
        #1;
        check_out0("rst_mid", 1'b0, 8'h00, 2'd0);
        check("rst_mid_ready", 64'(b0.in_ready), 64'(4'b0000));
        @(negedge clk);
        rst = 1'b0;

        // Round-robin sequence from pointer 0
        b1.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        b1.in_valid  = 4'b1111;
        b1.out_ready = 1'b1;
        #1;
        check("rr_first_ready", 64'(b1.in_ready), 64'(4'b0001));
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_seq_valid", 64'(b1.out_valid), 64'(1'b1));
            check("rr_seq_ch",    64'(b1.out_ch),    64'(k % 4));
            check("rr_seq_data",  64'(b1.out_data),  64'(8'h10 + (k % 4)));
        end

        // Wrap-around: move pointer to 3, then only ch1 valid
        b1.in_valid = 4'b0100;
        tick();
        check("rr_to3_ch", 64'(b1.out_ch), 64'(2'd2));
        b1.in_valid = 4'b0010;
        #1;
        check("rr_wrap_ready", 64'(b1.in_ready), 64'(4'b0010));
        tick();
        check("rr_wrap_ch", 64'(b1.out_ch), 64'(2'd1));
        b1.in_valid = 4'b1110;
        #1;
        check("rr_after_wrap_ready", 64'(b1.in_ready), 64'(4'b0100));
        tick();
        check("rr_after_wrap_ch", 64'(b1.out_ch), 64'(2'd2));
        // Idle cycle must leave the pointer at 3
        b1.in_valid = 4'b0000;
        tick();
        check("rr_idle_valid", 64'(b1.out_valid), 64'(1'b0));
        b1.in_valid = 4'b1111;
        #1;
        check("rr_idle_keep_ptr", 64'(b1.in_ready), 64'(4'b1000));
        b1.in_valid = 4'b0000;
        tick();

        // Randomised sweep with scoreboards (N=2 rr W=1, N=5 sel W=32)
        ptr2 = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            b2.in_valid  = 2'($urandom);
            b2.in_data   = 2'($urandom);
            b2.sel       = 1'($urandom);
            b2.out_ready = ($urandom_range(0, 3) != 0);
            b3.in_valid  = 5'($urandom);
            for (int i = 0; i < 5; i++) begin
                b3.in_data[i*32 +: 32] = $urandom;
            end
            b3.sel       = 3'($urandom_range(0, 7));
            b3.out_ready = ($urandom_range(0, 3) != 0);
            #1;

            check("sw2_valid", 64'(b2.out_valid), 64'(q2.size() > 0));
            le = (q2.size() == 0) || b2.out_ready;
            g  = -1;
            if (b2.in_valid[ptr2]) g = ptr2;
            else if (b2.in_valid[1-ptr2]) g = 1 - ptr2;
            expv = (le && g >= 0) ? (64'(1) << g) : 64'(0);
            check("sw2_in_ready", 64'(b2.in_ready), expv);
            if (q2.size() > 0 && b2.out_ready) begin
                item = q2.pop_front();
                check("sw2_data", 64'(b2.out_data), 64'(item[31:0]));
                check("sw2_ch",   64'(b2.out_ch),   64'(item[39:32]));
            end
            if (le && g >= 0) begin
                q2.push_back({8'(g), 32'(b2.in_data[g])});
                ptr2 = (g == 1) ? 0 : g + 1;
            end

            check("sw3_valid", 64'(b3.out_valid), 64'(q3.size() > 0));
            le = (q3.size() == 0) || b3.out_ready;
            g  = -1;
            if (int'(b3.sel) < 5 && b3.in_valid[b3.sel]) g = int'(b3.sel);
            expv = (le && g >= 0) ? (64'(1) << g) : 64'(0);
            check("sw3_in_ready", 64'(b3.in_ready), expv);
            if (q3.size() > 0 && b3.out_ready) begin
                item = q3.pop_front();
                check("sw3_data", 64'(b3.out_data), 64'(item[31:0]));
                check("sw3_ch",   64'(b3.out_ch),   64'(item[39:32]));
            end
            if (le && g >= 0) begin
                q3.push_back({8'(g), b3.in_data[g*32 +: 32]});
            end

            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
